// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction SRAM port of the IF stage.
//   inst_sram_en    fetch -> SRAM  read enable
//   inst_sram_wen   fetch -> SRAM  byte write enables (always 0)
//   inst_sram_addr  fetch -> SRAM  fetch address
//   inst_sram_wdata fetch -> SRAM  write data (always 0)
//   inst_sram_rdata SRAM -> fetch  data for the address issued the previous cycle
interface fetch_stage_if;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;

   modport master (
      output inst_sram_en,
      output inst_sram_wen,
      output inst_sram_addr,
      output inst_sram_wdata,
      input  inst_sram_rdata
   );

   modport slave (
      input  inst_sram_en,
      input  inst_sram_wen,
      input  inst_sram_addr,
      input  inst_sram_wdata,
      output inst_sram_rdata
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage MIPS32 pipeline.
//   Holds the fetch PC, selects the next PC (flush > stall > jr > jump > branch > pc+4)
//   with delay-slot semantics, keeps the decode-stage instruction stable across stalls
//   through a one-entry hold buffer and flags misaligned fetches (AdEL).
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   stall, flush       freeze IF / exception redirect to exc_pc (flush wins)
//   pc_d               PC of the instruction in decode
//   branch/jump/jr     decode redirect requests with extend_imm / instr_index / jr_src
//   sram               instruction SRAM master port (fetch_stage_if)
//   pc_f, inst_en_f    current fetch PC and fetch-issued flag for decode
//   instr_d            instruction belonging to pc_d
//   adel_f             fetch PC misaligned
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                stall,
   input  logic                flush,
   input  logic [31:0]         exc_pc,
   input  logic [31:0]         pc_d,
   input  logic                branch,
   input  logic                jump,
   input  logic                jr,
   input  logic [31:0]         extend_imm,
   input  logic [31:0]         jr_src,
   input  logic [25:0]         instr_index,
   fetch_stage_if.master       sram,
   output logic [31:0]         pc_f,
   output logic                inst_en_f,
   output logic [31:0]         instr_d,
   output logic                adel_f
);

   typedef enum logic {RUN, HOLD} state_e;

   state_e      state_q;
   logic [31:0] fetch_pc_q;
   logic [31:0] fetch_pc_d;
   logic [31:0] hold_q;
   logic [31:0] pc_d_plus4;
   logic [31:0] imm_shifted;

   assign pc_d_plus4  = pc_d + 32'd4;
   assign imm_shifted = extend_imm << 2;

   // Decode redirects are relative to the delay slot (pc_d+4), which is already
   // in fetch, so the target lands on the fetch after the slot.
   always_comb begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      if (flush)
         fetch_pc_d = exc_pc;
      else if (stall)
         fetch_pc_d = fetch_pc_q;
      else if (jr)
         fetch_pc_d = jr_src;
      else if (jump)
         fetch_pc_d = {pc_d_plus4[31:28], instr_index, 2'b00};
      else if (branch)
         fetch_pc_d = pc_d_plus4 + imm_shifted;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         fetch_pc_q <= RESET_PC;
         state_q    <= RUN;
         hold_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         if (flush) begin
            state_q <= RUN;
            hold_q  <= '0;
         end else begin
            case (state_q)
               // rdata at the stalling edge is the decode instruction; keep it
               // because the SRAM will start returning mem[pc_f] next cycle.
               RUN:  if (stall) begin
                        hold_q  <= sram.inst_sram_rdata;
                        state_q <= HOLD;
                     end
               HOLD: if (!stall) state_q <= RUN;
               default: state_q <= RUN;
            endcase
         end
      end
   end

   assign pc_f                 = fetch_pc_q;
   assign adel_f               = |fetch_pc_q[1:0];
   assign inst_en_f            = ~adel_f;
   assign sram.inst_sram_en    = ~adel_f;
   assign sram.inst_sram_addr  = fetch_pc_q;
   assign sram.inst_sram_wen   = '0;
   assign sram.inst_sram_wdata = '0;
   assign instr_d              = (state_q == HOLD) ? hold_q : sram.inst_sram_rdata;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
   localparam logic [31:0] RST_PC = 32'hbfc00000;

   logic        clk = 1'b0;
   logic        resetn, stall, flush, branch, jump, jr;
   logic [31:0] exc_pc, pc_d, extend_imm, jr_src;
   logic [25:0] instr_index;
   logic [31:0] pc_f, instr_d;
   logic        inst_en_f, adel_f;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   // reference model state
   logic [31:0] m_pc, m_rdata, m_held;
   logic        m_frozen, m_pc_ok, m_rd_ok;

   fetch_stage_if sif ();

   fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .resetn(resetn), .stall(stall), .flush(flush), .exc_pc(exc_pc),
      .pc_d(pc_d), .branch(branch), .jump(jump), .jr(jr), .extend_imm(extend_imm),
      .jr_src(jr_src), .instr_index(instr_index), .sram(sif.master),
      .pc_f(pc_f), .inst_en_f(inst_en_f), .instr_d(instr_d), .adel_f(adel_f)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'hbfc00008) return 32'h24020005;
      return {a[15:0], ~a[31:16]} ^ 32'h13572468;
   endfunction

   // synchronous SRAM, one cycle read latency
   always @(posedge clk)
      if (sif.inst_sram_en === 1'b1)
         sif.inst_sram_rdata <= mem_word(sif.inst_sram_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      resetn = 1'b1; stall = 1'b0; flush = 1'b0; branch = 1'b0; jump = 1'b0; jr = 1'b0;
   endtask

   // One clock: advance the model from the architectural rules, then compare.
   task automatic tick();
      logic [31:0] nxt, p4;
      logic        issue;
      p4    = pc_d + 32'd4;
      issue = m_pc_ok && (m_pc[1:0] == 2'b00);
      if (!resetn)     nxt = RST_PC;
      else if (flush)  nxt = exc_pc;
      else if (stall)  nxt = m_pc;
      else if (jr)     nxt = jr_src;
      else if (jump)   nxt = {p4[31:28], instr_index, 2'b00};
      else if (branch) nxt = p4 + {extend_imm[29:0], 2'b00};
      else             nxt = m_pc + 32'd4;
      // instruction shown to decode: frozen copy while a stall run lasts
      if (!resetn || flush) begin
         m_frozen = 1'b0; m_held = '0;
      end else if (stall && !m_frozen) begin
         m_frozen = 1'b1; m_held = m_rdata;
      end else if (!stall) begin
         m_frozen = 1'b0;
      end
      if (issue) m_rdata = mem_word(m_pc);
      m_rd_ok = m_rd_ok ? (issue || m_rd_ok) : issue;
      m_pc_ok = m_pc_ok || !resetn || flush || jr;
      m_pc    = nxt;
      @(posedge clk);
      #1;
      if (m_pc_ok) begin
         chk("pc_f", pc_f, m_pc);
         chk("adel_f", {31'd0, adel_f}, {31'd0, m_pc[1:0] != 2'b00});
         chk("inst_en_f", {31'd0, inst_en_f}, {31'd0, m_pc[1:0] == 2'b00});
         chk("sram_en", {31'd0, sif.inst_sram_en}, {31'd0, m_pc[1:0] == 2'b00});
         chk("sram_addr", sif.inst_sram_addr, m_pc);
         chk("sram_wen", {28'd0, sif.inst_sram_wen}, 32'd0);
         chk("sram_wdata", sif.inst_sram_wdata, 32'd0);
      end
      if (m_rd_ok || (m_frozen && m_pc_ok && resetn))
         chk("instr_d", instr_d, m_frozen ? m_held : m_rdata);
   endtask

   initial begin
      m_pc = '0; m_rdata = '0; m_held = '0; m_frozen = 1'b0; m_pc_ok = 1'b0; m_rd_ok = 1'b0;
      exc_pc = '0; pc_d = '0; extend_imm = '0; jr_src = '0; instr_index = '0;
      idle();

      // T1 reset then sequential fetch
      resetn = 1'b0; tick(); tick();
      idle();
      chk("t1_pc_reset", pc_f, 32'hbfc00000);
      chk("t1_en_reset", {31'd0, sif.inst_sram_en}, 32'd1);
      tick(); chk("t1_pc4", pc_f, 32'hbfc00004);
      tick(); chk("t1_pc8", pc_f, 32'hbfc00008);
      tick(); tick(); tick();                       // pc_f = bfc00014

      // T2 branch with delay slot at bfc00014
      pc_d = 32'hbfc00010; branch = 1'b1; extend_imm = 32'h00000003;
      tick(); idle();
      chk("t2_branch", pc_f, 32'hbfc00020);

      // T3 jr beats jump; then jump alone
      pc_d = 32'hbfc00100; jump = 1'b1; instr_index = 26'h0000040;
      jr = 1'b1; jr_src = 32'h80001000;
      tick(); chk("t3_jr_prio", pc_f, 32'h80001000);
      jr = 1'b0;
      tick(); idle(); chk("t3_jump", pc_f, 32'hb0000100);

      // T4 stall with bfc00008 in decode
      resetn = 1'b0; tick(); idle();
      tick(); tick(); tick();                       // pc_f = bfc0000c, decode holds bfc00008
      pc_d = 32'hbfc00008;
      chk("t4_pre", instr_d, 32'h24020005);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_hold_instr", instr_d, 32'h24020005);
         chk("t4_hold_pc", pc_f, 32'hbfc0000c);
      end
      stall = 1'b0;
      tick(); chk("t4_release", instr_d, mem_word(32'hbfc0000c));

      // T5 flush during stall
      stall = 1'b1; tick();
      flush = 1'b1; exc_pc = 32'hbfc00380;
      tick(); idle();
      chk("t5_flush_pc", pc_f, 32'hbfc00380);
      tick();

      // T6 misaligned target through jr
      jr = 1'b1; jr_src = 32'hbfc00002;
      tick(); idle();
      chk("t6_pc", pc_f, 32'hbfc00002);
      chk("t6_adel", {31'd0, adel_f}, 32'd1);
      chk("t6_en", {31'd0, sif.inst_sram_en}, 32'd0);
      chk("t6_en_f", {31'd0, inst_en_f}, 32'd0);
      tick(); stall = 1'b1; tick(); tick(); idle();
      exc_pc = RST_PC; flush = 1'b1; tick(); idle();

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         resetn      = ($urandom_range(0, 40) != 0);
         flush       = ($urandom_range(0, 15) == 0);
         stall       = ($urandom_range(0, 3) == 0);
         jr          = ($urandom_range(0, 9) == 0);
         jump        = ($urandom_range(0, 7) == 0);
         branch      = ($urandom_range(0, 5) == 0);
         exc_pc      = {$urandom} & (($urandom_range(0, 7) == 0) ? 32'hffffffff : 32'hfffffffc);
         jr_src      = {$urandom} & (($urandom_range(0, 7) == 0) ? 32'hffffffff : 32'hfffffffc);
         pc_d        = {$urandom} & 32'hfffffffc;
         if ($urandom_range(0, 15) == 0) pc_d = 32'hfffffffc;
         extend_imm  = {$urandom};
         instr_index = 26'($urandom);
         tick();
      end
      idle();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
